// File: rtl/mem_seq_pkg.sv
// Shared encodings for the memory access sequencer: request ops, FSM states,
// the empty-stack marker and the default stack bounds.
package mem_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_BYTE = 3'd3,
        OP_HALF = 3'd4,
        OP_WORD = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [31:0] DEF_SP_EMPTY         = 32'hFFFF_FFFF;
    localparam logic [31:0] DEF_USER_STACK_START = 32'd31;
    localparam logic [31:0] DEF_USER_STACK_END   = 32'd36;
    localparam logic [31:0] DEF_PRIV_STACK_START = 32'd37;
    localparam logic [31:0] DEF_PRIV_STACK_END   = 32'd42;

    // Index of the final beat, i.e. byte count minus one.
    function automatic logic [1:0] last_beat(input logic [2:0] op);
        case (op)
            OP_HALF: last_beat = 2'd1;
            OP_WORD: last_beat = 2'd3;
            default: last_beat = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/stack_bounds_check.sv
// Combinational PUSH/POP legality check: picks the user or privileged bounds,
// and yields the RAM slot, the next SP and whether SP must be written back.
module stack_bounds_check
    import mem_seq_pkg::*;
#(
    parameter logic [31:0] USER_STACK_START = DEF_USER_STACK_START,
    parameter logic [31:0] USER_STACK_END   = DEF_USER_STACK_END,
    parameter logic [31:0] PRIV_STACK_START = DEF_PRIV_STACK_START,
    parameter logic [31:0] PRIV_STACK_END   = DEF_PRIV_STACK_END,
    parameter logic [31:0] SP_EMPTY         = DEF_SP_EMPTY
) (
    input  logic [2:0]  op,
    input  logic        mode,
    input  logic [31:0] sp,
    output logic        fault,
    output logic        sp_we,
    output logic [31:0] addr,
    output logic [31:0] sp_next
);

    logic [31:0] lo, hi;

    always_comb begin
        lo      = mode ? PRIV_STACK_START : USER_STACK_START;
        hi      = mode ? PRIV_STACK_END   : USER_STACK_END;
        fault   = 1'b0;
        sp_we   = 1'b0;
        addr    = '0;
        sp_next = '0;
        if (op == OP_PUSH) begin
            if (sp == SP_EMPTY) begin
                addr    = hi;
                sp_next = hi;
                sp_we   = 1'b1;
            end else if (sp > lo && sp <= hi) begin
                addr    = sp - 32'd1;
                sp_next = sp - 32'd1;
                sp_we   = 1'b1;
            end else begin
                fault = 1'b1;
            end
        end else if (op == OP_POP) begin
            // An underflowing POP still resets SP to empty.
            sp_we = 1'b1;
            if (sp >= lo && sp < hi) begin
                addr    = sp;
                sp_next = sp + 32'd1;
            end else if (sp == hi) begin
                addr    = hi;
                sp_next = SP_EMPTY;
            end else begin
                fault   = 1'b1;
                sp_next = SP_EMPTY;
            end
        end
    end

endmodule

// File: rtl/memory_access_sequencer.sv
// Runs one CPU memory request at a time against a byte-wide synchronous RAM,
// one byte per cycle, descending from the base address.
module memory_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned ADDR_W           = 10,
    parameter logic [31:0] USER_STACK_START = DEF_USER_STACK_START,
    parameter logic [31:0] USER_STACK_END   = DEF_USER_STACK_END,
    parameter logic [31:0] PRIV_STACK_START = DEF_PRIV_STACK_START,
    parameter logic [31:0] PRIV_STACK_END   = DEF_PRIV_STACK_END,
    parameter logic [31:0] SP_EMPTY         = DEF_SP_EMPTY
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic              req_write,
    input  logic              req_mode,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       sp_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              fault,
    output logic              sp_we,
    output logic [31:0]       sp_out
);

    state_e      state, state_nx;
    logic        accept, is_stack, is_mem;
    logic        chk_fault, chk_sp_we;
    logic [31:0] chk_addr, chk_sp_next;
    logic        acc_fault, acc_write;
    logic [31:0] acc_base;
    logic [1:0]  acc_last;

    logic        write_q, fault_q, sp_we_q, cap_vld;
    logic [1:0]  cnt, last_q, cap_idx;
    logic [31:0] base_q, wdata_q, sp_out_q, rdata_q;

    stack_bounds_check #(
        .USER_STACK_START(USER_STACK_START),
        .USER_STACK_END  (USER_STACK_END),
        .PRIV_STACK_START(PRIV_STACK_START),
        .PRIV_STACK_END  (PRIV_STACK_END),
        .SP_EMPTY        (SP_EMPTY)
    ) u_bounds (
        .op     (req_op),
        .mode   (req_mode),
        .sp     (sp_in),
        .fault  (chk_fault),
        .sp_we  (chk_sp_we),
        .addr   (chk_addr),
        .sp_next(chk_sp_next)
    );

    always_comb begin
        is_stack  = (req_op == OP_PUSH) || (req_op == OP_POP);
        is_mem    = (req_op == OP_BYTE) || (req_op == OP_HALF) || (req_op == OP_WORD);
        acc_last  = last_beat(req_op);
        acc_write = (req_op == OP_PUSH) || (is_mem && req_write);
        acc_base  = is_stack ? chk_addr : req_addr;
        // Lowest byte is base-(n-1), so the base must be at least n-1 and inside the RAM.
        acc_fault = is_stack ? chk_fault
                  : is_mem && ((req_addr < {30'd0, acc_last}) || (|(req_addr >> ADDR_W)));
    end

    assign accept = req_valid && (state == IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nx = (acc_fault || !(is_stack || is_mem)) ? RESP : XFER;
            end
            XFER: begin
                mem_addr  = ADDR_W'(base_q - 32'(cnt));
                mem_we    = write_q;
                mem_wdata = wdata_q[{cnt, 3'b000} +: 8];
                if (cnt == last_q) state_nx = write_q ? RESP : CAPT;
            end
            CAPT: state_nx = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign fault     = rsp_valid && fault_q;
    assign sp_we     = rsp_valid && sp_we_q;
    assign sp_out    = sp_out_q;
    assign rsp_rdata = rdata_q;

    // Read byte k arrives one cycle after its beat; cap_vld/cap_idx carry the beat across.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_q  <= 1'b0;
            fault_q  <= 1'b0;
            sp_we_q  <= 1'b0;
            cap_vld  <= 1'b0;
            cnt      <= '0;
            last_q   <= '0;
            cap_idx  <= '0;
            base_q   <= '0;
            wdata_q  <= '0;
            sp_out_q <= '0;
            rdata_q  <= '0;
        end else begin
            cap_vld <= 1'b0;
            if (accept) begin
                write_q  <= acc_write;
                fault_q  <= acc_fault;
                sp_we_q  <= is_stack && chk_sp_we;
                sp_out_q <= chk_sp_next;
                base_q   <= acc_base;
                wdata_q  <= req_wdata;
                last_q   <= acc_last;
                cnt      <= '0;
                rdata_q  <= '0;
            end
            if (state == XFER) begin
                cnt <= cnt + 2'd1;
                if (!write_q) begin
                    cap_vld <= 1'b1;
                    cap_idx <= cnt;
                end
            end
            if (cap_vld) rdata_q[{cap_idx, 3'b000} +: 8] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Randomized bench for memory_access_sequencer: a RAM model on the memory port
// and a per-cycle expected-output queue built from the request rules.
module tb_memory_access_sequencer;

    localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic        req_write = 1'b0;
    logic        req_mode = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] sp_in = '0;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        fault;
    logic        sp_we;
    logic [31:0] sp_out;

    always #5 clock = ~clock;

    memory_access_sequencer dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_write(req_write), .req_mode(req_mode), .req_addr(req_addr),
        .req_wdata(req_wdata), .sp_in(sp_in),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .fault(fault),
        .sp_we(sp_we), .sp_out(sp_out)
    );

    // Byte RAM with 1-cycle read; the preload port fills it during reset.
    logic [7:0] ram [1024];
    logic       pl_we = 1'b0;
    logic [9:0] pl_addr = '0;
    logic [7:0] pl_data = '0;

    always @(posedge clock) begin
        if (pl_we)       ram[pl_addr]  <= pl_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic        ready;
        logic [9:0]  addr;
        logic        we;
        logic [7:0]  wd;
        logic        rsp;
        logic        flt;
        logic [31:0] rd;
        logic        spwe;
        logic [31:0] spo;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mdl_ram [1024];
    int          checks = 0, errors = 0, cyc = 0, rsp_cyc = 0, prev_rsp_cyc = 0;
    logic        chk_en = 1'b0;
    logic        last_fault = 1'b0, last_spwe = 1'b0;
    logic [31:0] last_rdata = '0, last_spout = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t blank();
        exp_t e;
        e.ready = 1'b0; e.addr = '0; e.we = 1'b0; e.wd = '0;
        e.rsp = 1'b0; e.flt = 1'b0; e.rd = '0; e.spwe = 1'b0; e.spo = '0;
        return e;
    endfunction

    // Expected outputs for the accept cycle and every cycle up to the response.
    task automatic model(input logic [2:0] op, input logic wr, input logic md,
                         input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] sp,
                         output int len);
        exp_t        e;
        logic [31:0] lo, hi, base, nsp, rd;
        logic        flt, spwe, go, isw;
        int          n;
        lo = md ? 32'd37 : 32'd31;
        hi = md ? 32'd42 : 32'd36;
        n  = (op == 3'd4) ? 2 : (op == 3'd5) ? 4 : 1;
        flt = 1'b0; spwe = 1'b0; go = 1'b0; isw = wr; base = ad; nsp = '0; rd = '0;
        case (op)
            3'd1: begin
                isw = 1'b1;
                if (sp == EMPTY) begin base = hi; nsp = hi; go = 1'b1; spwe = 1'b1; end
                else if (sp > lo && sp <= hi) begin
                    base = sp - 32'd1; nsp = sp - 32'd1; go = 1'b1; spwe = 1'b1;
                end else flt = 1'b1;
            end
            3'd2: begin
                isw = 1'b0; spwe = 1'b1;
                if (sp >= lo && sp < hi) begin base = sp; nsp = sp + 32'd1; go = 1'b1; end
                else if (sp == hi) begin base = hi; nsp = EMPTY; go = 1'b1; end
                else begin flt = 1'b1; nsp = EMPTY; end
            end
            3'd3, 3'd4, 3'd5: begin
                if (ad < 32'(n - 1) || ad > 32'd1023) flt = 1'b1;
                else go = 1'b1;
            end
            default: ;
        endcase
        e = blank(); e.ready = 1'b1; exp_q.push_back(e);
        len = 0;
        if (go) begin
            for (int k = 0; k < n; k++) begin
                logic [9:0] a;
                a = 10'(base - 32'(k));
                e = blank(); e.addr = a; e.we = isw; e.wd = wd[8*k +: 8];
                if (isw) mdl_ram[a] = wd[8*k +: 8];
                else     rd[8*k +: 8] = mdl_ram[a];
                exp_q.push_back(e); len++;
            end
            if (!isw) begin exp_q.push_back(blank()); len++; end
        end
        e = blank(); e.rsp = 1'b1; e.flt = flt; e.rd = rd; e.spwe = spwe; e.spo = nsp;
        exp_q.push_back(e); len++;
    endtask

    task automatic scramble();
        req_valid = 1'($urandom_range(0, 1));
        req_op    = 3'($urandom);
        req_write = 1'($urandom);
        req_mode  = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        sp_in     = $urandom;
    endtask

    // Called just after a clock edge with the DUT idle; returns when it is idle again.
    task automatic issue(input logic [2:0] op, input logic wr, input logic md,
                         input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] sp);
        int len;
        req_valid = 1'b1; req_op = op; req_write = wr; req_mode = md;
        req_addr = ad; req_wdata = wd; sp_in = sp;
        model(op, wr, md, ad, wd, sp, len);
        repeat (len + 1) begin
            @(posedge clock); #1;
            scramble();
        end
    endtask

    task automatic idle_cycle();
        exp_t e;
        req_valid = 1'b0;
        e = blank(); e.ready = 1'b1;
        exp_q.push_back(e);
        @(posedge clock); #1;
    endtask

    initial begin : compare
        exp_t e;
        forever begin
            @(negedge clock);
            cyc++;
            if (chk_en) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL queue_underrun: no expected entry at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("req_ready", 32'(req_ready), 32'(e.ready));
                    chk("mem_we",    32'(mem_we),    32'(e.we));
                    chk("mem_addr",  32'(mem_addr),  32'(e.addr));
                    chk("mem_wdata", 32'(mem_wdata), 32'(e.wd));
                    chk("rsp_valid", 32'(rsp_valid), 32'(e.rsp));
                    if (e.rsp) begin
                        chk("fault",     32'(fault), 32'(e.flt));
                        chk("rsp_rdata", rsp_rdata,  e.rd);
                        chk("sp_we",     32'(sp_we), 32'(e.spwe));
                        if (e.spwe) chk("sp_out", sp_out, e.spo);
                    end else begin
                        chk("sp_we_idle", 32'(sp_we), 32'd0);
                    end
                end
                if (rsp_valid) begin
                    prev_rsp_cyc = rsp_cyc; rsp_cyc = cyc;
                    last_fault = fault; last_spwe = sp_we;
                    last_rdata = rsp_rdata; last_spout = sp_out;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin : stim
        reset = 1'b0;
        for (int a = 0; a < 1024; a++) begin
            logic [7:0] v;
            v = 8'($urandom);
            if (a >= 97 && a <= 100)  v = 8'(101 - a) * 8'h11;
            if (a >= 497 && a <= 500) v = 8'hEE;
            mdl_ram[a] = v;
            pl_we = 1'b1; pl_addr = 10'(a); pl_data = v;
            @(posedge clock); #1;
        end
        pl_we = 1'b0;

        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mem_we",    32'(mem_we),    32'd0);
        chk("rst_mem_addr",  32'(mem_addr),  32'd0);
        chk("rst_sp_out",    sp_out,         32'd0);
        chk("rst_rsp_rdata", rsp_rdata,      32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk_en = 1'b1;

        issue(3'd1, 1'b0, 1'b0, 32'd0, 32'h0000_005A, EMPTY);
        chk("push_sp_out", last_spout, 32'd36);
        chk("push_ram36",  32'(ram[36]), 32'h5A);
        chk("push_fault",  32'(last_fault), 32'd0);

        issue(3'd5, 1'b0, 1'b0, 32'd100, 32'd0, 32'd0);
        chk("word_load", last_rdata, 32'h4433_2211);

        issue(3'd2, 1'b0, 1'b1, 32'd0, 32'd0, 32'd42);
        chk("ppop_sp_out", last_spout, EMPTY);
        chk("ppop_fault",  32'(last_fault), 32'd0);

        issue(3'd2, 1'b0, 1'b0, 32'd0, 32'd0, 32'd20);
        chk("upop_fault", 32'(last_fault), 32'd1);
        chk("upop_sp_we", 32'(last_spwe),  32'd1);
        chk("upop_sp",    last_spout,      EMPTY);

        issue(3'd1, 1'b0, 1'b0, 32'd0, 32'h77, 32'd31);
        chk("ovf_fault", 32'(last_fault), 32'd1);
        chk("ovf_sp_we", 32'(last_spwe),  32'd0);

        issue(3'd4, 1'b1, 1'b0, 32'd0, 32'h1234, 32'd0);
        chk("half0_fault", 32'(last_fault), 32'd1);

        issue(3'd5, 1'b1, 1'b0, 32'd600, 32'hCAFE_F00D, 32'd0);
        issue(3'd5, 1'b0, 1'b0, 32'd600, 32'd0, 32'd0);
        chk("rsp_gap",  32'(rsp_cyc - prev_rsp_cyc), 32'd7);
        chk("readback", last_rdata, 32'hCAFE_F00D);

        issue(3'd1, 1'b0, 1'b0, 32'd0, 32'h3C, 32'd36);
        chk("rt_push_sp", last_spout, 32'd35);
        issue(3'd2, 1'b0, 1'b0, 32'd0, 32'd0, 32'd35);
        chk("rt_pop_rd", last_rdata, 32'h3C);
        chk("rt_pop_sp", last_spout, 32'd36);

        // Abort a word store to 500 during its third beat.
        chk_en = 1'b0;
        req_valid = 1'b1; req_op = 3'd5; req_write = 1'b1; req_mode = 1'b0;
        req_addr = 32'd500; req_wdata = 32'hA1B2_C3D4; sp_in = 32'd0;
        @(posedge clock); #1; req_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("abort_pre_we",   32'(mem_we),   32'd1);
        chk("abort_pre_addr", 32'(mem_addr), 32'd498);
        reset = 1'b0; #1;
        chk("abort_mem_we",    32'(mem_we),    32'd0);
        chk("abort_mem_addr",  32'(mem_addr),  32'd0);
        chk("abort_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_sp_out",    sp_out,         32'd0);
        chk("abort_rsp_rdata", rsp_rdata,      32'd0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("abort_ram500", 32'(ram[500]), 32'hD4);
        chk("abort_ram499", 32'(ram[499]), 32'hC3);
        chk("abort_ram498", 32'(ram[498]), 32'hEE);
        chk("abort_ram497", 32'(ram[497]), 32'hEE);
        mdl_ram[500] = 8'hD4;
        mdl_ram[499] = 8'hC3;

        chk_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ad, sp;
            int          gap;
            gap = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) repeat (gap) idle_cycle();
            case ($urandom_range(0, 3))
                0:       ad = $urandom_range(0, 3);
                3:       ad = $urandom;
                default: ad = $urandom_range(0, 1023);
            endcase
            case ($urandom_range(0, 3))
                0:       sp = EMPTY;
                3:       sp = $urandom;
                default: sp = $urandom_range(28, 45);
            endcase
            issue(3'($urandom), 1'($urandom), 1'($urandom), ad, $urandom, sp);
        end
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_access_sequencer.md
# memory_access_sequencer

Multi-cycle controller that executes one CPU memory request at a time against a single-port, byte-wide data RAM with 1-cycle synchronous read. Covers stack PUSH/POP with user/privileged bounds checking and SP update, and 1/2/4-byte loads/stores, issued one byte per cycle. Sits between the control unit/register bank and the data RAM, and replaces combinational parallel byte-address generation with a sequenced, handshaked access.

## Interface
Parameters:
- ADDR_W, 10, RAM address width.
- USER_STACK_START, 31, lowest user stack slot.
- USER_STACK_END, 36, highest user stack slot; the first push lands here.
- PRIV_STACK_START, 37, lowest privileged stack slot.
- PRIV_STACK_END, 42, highest privileged stack slot.
- SP_EMPTY, 32'hFFFF_FFFF, SP value meaning "stack empty".

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on req_valid & req_ready.
- req_op  in  3  0 NOP, 1 PUSH, 2 POP, 3 byte, 4 half, 5 word, 6/7 NOP.
- req_write  in  1  store when high, for ops 3-5; ignored otherwise.
- req_mode  in  1  0 user stack, 1 privileged stack.
- req_addr  in  32  access address for ops 3-5, the byte-0 address.
- req_wdata  in  32  store/push data; PUSH uses [7:0].
- sp_in  in  32  current SP.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  8  RAM write byte.
- mem_rdata  in  8  RAM read byte, valid the cycle after mem_addr.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  assembled read data, zero-extended.
- fault  out  1  qualified by rsp_valid; overflow, underflow or bad address.
- sp_we  out  1  pulses with rsp_valid when SP changes.
- sp_out  out  32  new SP, valid while sp_we is high.

## Operation
- States: IDLE, XFER, CAPT, RESP.
- IDLE -> XFER on accept with no fault.
- IDLE -> RESP on accept of a NOP or a faulting request.
- XFER -> RESP after the last byte of a write; XFER -> CAPT after the last byte of a read.
- CAPT -> RESP; RESP -> IDLE.
- On accept, latch op, mode, data and base address, and compute byte count n: 1 for PUSH/POP/byte, 2 for half, 4 for word.
- Byte k is at address base-k and maps to data bits [8k+7:8k]. Address arithmetic is done in 32 bits.
- XFER beat k (k=0..n-1): mem_addr=base-k, mem_we=write, mem_wdata=wdata byte k.
- Read data for beat k is captured into rsp_rdata byte k on the following cycle.
- PUSH, SP==SP_EMPTY: write at STACK_END; sp_out=STACK_END.
- PUSH, START<SP<=END: write at SP-1; sp_out=SP-1.
- PUSH, any other SP: fault (overflow).
- POP, START<=SP<END: read at SP; sp_out=SP+1.
- POP, SP==END: read at END; sp_out=SP_EMPTY.
- POP, any other SP: fault (underflow); sp_out=SP_EMPTY with sp_we=1, rsp_rdata=0.
- START/END are the user or privileged bounds, selected by req_mode.
- Ops 3-5 fault, with no RAM beat, when req_addr < n-1 or req_addr > 2^ADDR_W-1.
- On any fault: mem_we is never asserted, and sp_we=0 except for POP underflow.
- rsp_rdata is cleared on accept and held after RESP until the next accept.
- Outside XFER: mem_we=0, mem_addr=0, mem_wdata=0.

## Timing
- Accept happens at edge 0.
- Write/PUSH: beats in cycles 1..n; rsp_valid in cycle n+1.
- Read/POP: beats in cycles 1..n, CAPT in cycle n+1, rsp_valid in cycle n+2.
- Fault or NOP: rsp_valid in cycle 1.
- req_ready=0 from the cycle after accept through RESP, so the earliest next accept is the cycle after RESP.
- Inputs other than req_* are sampled only at accept. sp_in is sampled once.
- Reset assertion mid-transfer immediately forces:
  - state IDLE, so req_ready=1 once reset is released;
  - mem_we=0, mem_addr=0, mem_wdata=0;
  - rsp_valid=0, fault=0, sp_we=0, sp_out=0, rsp_rdata=0.
- The aborted request is dropped with no response.

## Structure
- Shared package mem_seq_pkg holds:
  - op encodings (OP_NOP, OP_PUSH, OP_POP, OP_BYTE, OP_HALF, OP_WORD);
  - the state encoding;
  - SP_EMPTY and the four stack-bound defaults.
- One combinational sub-module, stack_bounds_check, takes op, mode and SP, and returns fault, target address and next SP.
- The FSM, beat counter (2 bits) and data shifter stay in memory_access_sequencer.

## Test plan
- User PUSH, sp_in=FFFF_FFFF, wdata=0x5A -> cycle 1 write 0x5A at 36; cycle 2 rsp_valid, sp_we, sp_out=36, fault=0.
- Word load, addr=100, RAM[100..97]=11,22,33,44 -> beats at 100,99,98,97; rsp_valid at cycle 6 with rsp_rdata=0x44332211.
- Privileged POP, sp_in=42 -> read at 42; sp_out=FFFF_FFFF.
- User POP, sp_in=20 -> no RAM beat; rsp_valid at cycle 1, fault=1, sp_out=FFFF_FFFF.
- User PUSH, sp_in=31 -> fault=1, no mem_we, sp_we=0.
- Half store, addr=0 -> fault=1, no write.
- Word store, addr=500, reset pulsed low in beat 2 -> mem_we drops immediately; only RAM[500] and [499] written; no rsp_valid; req_ready=1 after release.
- req_valid held high continuously -> accepts spaced by n+2 (write) or n+3 (read) cycles.
